dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single data memory (32-bit words, 12-bit address, registered read, 1-cycle write) between the CPU load/store unit and an auxiliary master (debug/DMA/IO loader).
- Sits between both requesters and the data memory instance.
- Sequences each access through a 3-state FSM and returns read data with a one-cycle acknowledge.
- Memory read_clock and write_clock are tied to `clock` at the top level.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter sharing one registered-read data memory
// Optional DMEM_ARB_CPU_PRIORITY_EN: fixed CPU priority instead of round-robin.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  aux_ack,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_AUX = 1'b1;

  state_t                state_q, state_d;
  logic                  win;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  aux_ack_q, aux_ack_d;
  logic                  mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_CPU;
      last_grant_q <= GRANT_AUX;
      cpu_ack_q    <= 1'b0;
      aux_ack_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      mem_data_q   <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cpu_ack_q    <= cpu_ack_d;
      aux_ack_q    <= aux_ack_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      mem_data_q   <= mem_data_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

  // Winner selection: a lone requester wins; under contention the master not served last wins.
  always_comb begin
    win     = GRANT_CPU;
    state_d = state_q;
    if (cpu_req && aux_req) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
      win = GRANT_CPU;
`else
      win = (last_grant_q == GRANT_AUX) ? GRANT_CPU : GRANT_AUX;
`endif
    end else if (aux_req) begin
      win = GRANT_AUX;
    end
    case (state_q)
      IDLE:    if (cpu_req || aux_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_data_d   = mem_data_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    cpu_ack_d    = 1'b0;
    aux_ack_d    = 1'b0;
    mem_we_d     = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (cpu_req || aux_req) begin
          grant_d      = win;
          last_grant_d = win;
          mem_we_d     = (win == GRANT_AUX) ? aux_we : cpu_we;
          rd_addr_d    = (win == GRANT_AUX) ? aux_addr : cpu_addr;
          wr_addr_d    = (win == GRANT_AUX) ? aux_addr : cpu_addr;
          mem_data_d   = (win == GRANT_AUX) ? aux_wdata : cpu_wdata;
        end
      end
      ACCESS: begin
        cpu_ack_d = (grant_q == GRANT_CPU);
        aux_ack_d = (grant_q == GRANT_AUX);
      end
      default: ;
    endcase
  end

  assign cpu_ack        = cpu_ack_q;
  assign aux_ack        = aux_ack_q;
  assign mem_we         = mem_we_q;
  assign busy           = busy_q;
  assign mem_data       = mem_data_q;
  assign mem_read_addr  = rd_addr_q;
  assign mem_write_addr = wr_addr_q;
  // Read data is gated so a requester never sees another master's word.
  assign cpu_rdata      = cpu_ack_q ? mem_q : '0;
  assign aux_rdata      = aux_ack_q ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural registered-read memory
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, aux_req = 1'b0, aux_we = 1'b0;
  logic [11:0] cpu_addr = '0, aux_addr = '0;
  logic [31:0] cpu_wdata = '0, aux_wdata = '0;
  logic        cpu_ack, aux_ack, mem_we, busy;
  logic [31:0] cpu_rdata, aux_rdata, mem_data;
  logic [31:0] mem_q;
  logic [11:0] mem_read_addr, mem_write_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          aux;
    bit          we;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          aux;
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[8];

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_data(mem_data), .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_we(mem_we), .mem_q(mem_q), .busy(busy)
  );

  logic [31:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = '0;
  always @(posedge clock) begin
    if (mem_we) mem[mem_write_addr] <= mem_data;
    mem_q <= mem[mem_read_addr];
  end

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every ack must match the oldest pending expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (!cpu_ack) chk("cpu_rdata_idle_zero", cpu_rdata, 32'h0);
      if (!aux_ack) chk("aux_rdata_idle_zero", aux_rdata, 32'h0);
      if (cpu_ack || aux_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'h0, aux_ack, cpu_ack}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_master_cpu", {31'h0, cpu_ack}, {31'h0, !e.aux});
          chk("ack_master_aux", {31'h0, aux_ack}, {31'h0, e.aux});
          chk("ack_cycle", cyc, e.cyc);
          if (!e.we) chk("read_data", e.aux ? aux_rdata : cpu_rdata, e.rdata);
        end
      end
    end
  end

  task automatic drive(input bit aux, input bit req, input bit we,
                       input logic [11:0] addr, input logic [31:0] wdata);
    if (aux) begin
      aux_req = req; aux_we = we; aux_addr = addr; aux_wdata = wdata;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic wait_ack(input bit aux, input bit any, input string name);
    bit seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clock);
      if (any ? (cpu_ack || aux_ack) : (aux ? aux_ack : cpu_ack)) seen = 1;
    end
    chk(name, {31'h0, seen}, 32'h1);
  endtask

  task automatic do_single(input bit aux, input bit we, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int t0;
    @(posedge clock); #1;
    drive(aux, 1'b1, we, addr, wdata);
    t0 = cyc;
    sb.push_back('{aux, we, exp_rdata, t0 + 2});
    @(negedge clock);
    @(negedge clock);
    chk("access_mem_we", {31'h0, mem_we}, {31'h0, we});
    chk("access_wr_addr", {20'h0, mem_write_addr}, {20'h0, addr});
    chk("access_rd_addr", {20'h0, mem_read_addr}, {20'h0, addr});
    chk("access_data", mem_data, wdata);
    chk("access_busy", {31'h0, busy}, 32'h1);
    wait_ack(aux, 1'b0, "single_ack_timeout");
    chk("resp_mem_we_low", {31'h0, mem_we}, 32'h0);
    chk("resp_busy", {31'h0, busy}, 32'h1);
    @(posedge clock); #1;
    drive(aux, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  initial begin
    int t0;
    vecs[0] = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 12'h020, 32'h0, 32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 12'hFFF, 32'hA5A5A5A5, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 12'h000, 32'h5A5A5A5A, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 12'hFFF, 32'h0, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 1'b0, 12'h000, 32'h0, 32'h5A5A5A5A};
    vecs[7] = '{1'b1, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_cpu_ack", {31'h0, cpu_ack}, 32'h0);
    chk("reset_aux_ack", {31'h0, aux_ack}, 32'h0);
    chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
    chk("reset_mem_data", mem_data, 32'h0);
    chk("reset_rd_addr", {20'h0, mem_read_addr}, 32'h0);
    chk("reset_wr_addr", {20'h0, mem_write_addr}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // First contention after reset: CPU must win, aux served one pass later.
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b0, 12'h010, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 12'h020, 32'h12345678);
    t0 = cyc;
    sb.push_back('{1'b0, 1'b0, 32'h0, t0 + 2});
    sb.push_back('{1'b1, 1'b1, 32'h0, t0 + 5});
    wait_ack(1'b0, 1'b0, "contend_cpu_timeout");
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    wait_ack(1'b1, 1'b0, "contend_aux_timeout");
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);

    for (int i = 0; i < 8; i++)
      do_single(vecs[i].aux, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Both masters hold req for four back-to-back accesses.
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b0, 12'h010, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 12'h020, 32'h0);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
      sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF, t0 + 2 + 3 * i});
`else
      if (i % 2 == 0) sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF, t0 + 2 + 3 * i});
      else            sb.push_back('{1'b1, 1'b0, 32'h12345678, t0 + 2 + 3 * i});
`endif
    end
    for (int i = 0; i < 4; i++) wait_ack(1'b0, 1'b1, "stream_ack_timeout");
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
    repeat (2) @(posedge clock);

    // Reset during ACCESS of a CPU read; req stays high and is re-issued.
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b0, 12'h010, 32'h0);
    t0 = cyc;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF, t0 + 4});
    @(negedge clock);
    chk("midreset_busy", {31'h0, busy}, 32'h0);
    chk("midreset_cpu_ack", {31'h0, cpu_ack}, 32'h0);
    chk("midreset_mem_we", {31'h0, mem_we}, 32'h0);
    wait_ack(1'b0, 1'b0, "reissue_ack_timeout");
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);

    // Aux drops req during ACCESS; the write still lands and ack still pulses.
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 1'b1, 12'h030, 32'h00000077);
    t0 = cyc;
    sb.push_back('{1'b1, 1'b1, 32'h0, t0 + 2});
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
    wait_ack(1'b1, 1'b0, "drop_ack_timeout");
    do_single(1'b0, 1'b0, 12'h030, 32'h0, 32'h00000077);

    repeat (4) @(posedge clock);
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
